multicycle_control: RTL and testbench

Main control FSM for the multi-cycle Mini-MIPS datapath, sitting directly upstream of the ALU. It decodes the instruction held in the instruction register and drives every datapath strobe, including the 6-bit ALU control code. It consumes the ALU's `operands_are_equal` flag to resolve branches. It also stalls on a memory-ready handshake and counts retired instructions.

---
 rtl/multicycle_control_pkg.sv | 56 +++++
 rtl/multicycle_control_alu_decoder.sv | 47 ++++
 rtl/multicycle_control.sv | 176 +++++++++++++++++
 tb/tb_multicycle_control.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle Mini-MIPS control FSM:
// state codes, opcodes, funct values, ALU codes and mux selects.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;

  localparam logic [5:0] ALU_CONTROL_ADD = 6'h20;
  localparam logic [5:0] ALU_CONTROL_SUB = 6'h22;
  localparam logic [5:0] ALU_CONTROL_AND = 6'h24;
  localparam logic [5:0] ALU_CONTROL_OR  = 6'h25;
  localparam logic [5:0] ALU_CONTROL_XOR = 6'h26;

  localparam logic [1:0] SRCB_REG    = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_BRANCH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  function automatic logic is_logic_imm(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Opcode/funct to ALU control code, with a legal flag covering
// every R-type and immediate arithmetic instruction.
module alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output logic [5:0] o_alu_control,
  output logic       o_legal
);

  always_comb begin
    o_alu_control = ALU_CONTROL_ADD;
    o_legal       = 1'b0;
    unique case (i_opcode)
      OP_RTYPE: begin
        o_legal = 1'b1;
        unique case (i_funct)
          FN_ADD:  o_alu_control = ALU_CONTROL_ADD;
          FN_SUB:  o_alu_control = ALU_CONTROL_SUB;
          FN_AND:  o_alu_control = ALU_CONTROL_AND;
          FN_OR:   o_alu_control = ALU_CONTROL_OR;
          FN_XOR:  o_alu_control = ALU_CONTROL_XOR;
          default: o_legal = 1'b0;
        endcase
      end
      OP_ADDI: begin
        o_legal       = 1'b1;
        o_alu_control = ALU_CONTROL_ADD;
      end
      OP_ANDI: begin
        o_legal       = 1'b1;
        o_alu_control = ALU_CONTROL_AND;
      end
      OP_ORI: begin
        o_legal       = 1'b1;
        o_alu_control = ALU_CONTROL_OR;
      end
      OP_XORI: begin
        o_legal       = 1'b1;
        o_alu_control = ALU_CONTROL_XOR;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle Mini-MIPS datapath: decodes
// the IR, drives every datapath strobe and counts retired instructions.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  instr_opcode,
  input  logic [5:0]  instr_funct,
  input  logic        operands_are_equal,
  input  logic        mem_ready,
  output logic [5:0]  alu_control,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        zero_ext,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        i_or_d,
  output logic [1:0]  pc_source,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic [3:0]  state,
  output logic        illegal_instr,
  output logic [31:0] retired
);

  state_e      r_state;
  state_e      w_next;
  logic [31:0] r_retired;
  logic [5:0]  w_alu_ctrl;
  logic        w_alu_legal;
  logic        w_is_mem;
  logic        w_is_br;
  logic        w_is_j;
  logic        w_is_r;
  logic        w_is_i;
  logic        w_known;
  logic        w_retire;

  alu_decoder u_alu_dec (
    .i_opcode      (instr_opcode),
    .i_funct       (instr_funct),
    .o_alu_control (w_alu_ctrl),
    .o_legal       (w_alu_legal)
  );

  assign w_is_mem = (instr_opcode == OP_LW) ||
                    (instr_opcode == OP_SW);
  assign w_is_br  = (instr_opcode == OP_BEQ) ||
                    (instr_opcode == OP_BNE);
  assign w_is_j   = (instr_opcode == OP_J);
  assign w_is_r   = w_alu_legal && (instr_opcode == OP_RTYPE);
  assign w_is_i   = w_alu_legal && (instr_opcode != OP_RTYPE);
  assign w_known  = w_is_mem | w_is_br | w_is_j | w_alu_legal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          w_is_mem: w_next = S_MEM_ADDR;
          w_is_r:   w_next = S_R_EXEC;
          w_is_br:  w_next = S_BRANCH;
          w_is_j:   w_next = S_JUMP;
          w_is_i:   w_next = S_I_EXEC;
          default:  w_next = S_FETCH;
        endcase
      end
      S_MEM_ADDR:
        w_next = (instr_opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  w_next = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: w_next = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    w_next = S_R_WB;
      S_I_EXEC:    w_next = S_I_WB;
      default:     w_next = S_FETCH;
    endcase
  end

  always_comb begin
    alu_control   = ALU_CONTROL_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    zero_ext      = 1'b0;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    i_or_d        = 1'b0;
    pc_source     = PCSRC_ALU;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    illegal_instr = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b     = SRCB_BRANCH;
        illegal_instr = !w_known;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a   = 1'b1;
        alu_control = w_alu_ctrl;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_control = ALU_CONTROL_SUB;
        alu_src_a   = 1'b1;
        pc_source   = PCSRC_ALUOUT;
        pc_write    =
          ((instr_opcode == OP_BEQ) &&  operands_are_equal) ||
          ((instr_opcode == OP_BNE) && !operands_are_equal);
      end
      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_write  = 1'b1;
      end
      S_I_EXEC, S_I_WB: begin
        alu_control = w_alu_ctrl;
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_IMM;
        zero_ext    = is_logic_imm(instr_opcode);
        reg_write   = (r_state == S_I_WB);
      end
      default: ;
    endcase
  end

  // Count on the edge that leaves the final state of a legal instruction.
  assign w_retire =
    (r_state == S_MEM_WB) || (r_state == S_R_WB) ||
    (r_state == S_BRANCH) || (r_state == S_JUMP) ||
    (r_state == S_I_WB) ||
    ((r_state == S_MEM_WRITE) && mem_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_retired <= 32'd0;
    else if (w_retire) r_retired <= r_retired + 32'd1;
  end

  assign state   = r_state;
  assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level cycle scripts,
// directed cases first, then random instructions and stalls.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  typedef struct packed {
    logic [3:0]  st;
    logic [5:0]  alu;
    logic        sa;
    logic [1:0]  sb;
    logic        zx;
    logic        pcw;
    logic        irw;
    logic        mr;
    logic        mw;
    logic        rw;
    logic        iod;
    logic [1:0]  ps;
    logic        m2r;
    logic        rd;
    logic        ill;
    logic [31:0] ret;
  } obs_t;

  typedef struct packed {
    obs_t o;
    logic mrdy;
    logic eq;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  instr_opcode = 6'h00;
  logic [5:0]  instr_funct = 6'h00;
  logic        operands_are_equal = 1'b0;
  logic        mem_ready = 1'b1;
  logic [5:0]  alu_control;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        zero_ext;
  logic        pc_write;
  logic        ir_write;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        i_or_d;
  logic [1:0]  pc_source;
  logic        mem_to_reg;
  logic        reg_dst;
  logic [3:0]  state;
  logic        illegal_instr;
  logic [31:0] retired;

  int          n_chk = 0;
  int          n_pass = 0;
  int          cnt = 0;
  ent_t        q[$];

  multicycle_control dut (
    .clk(clk), .reset(reset),
    .instr_opcode(instr_opcode), .instr_funct(instr_funct),
    .operands_are_equal(operands_are_equal),
    .mem_ready(mem_ready),
    .alu_control(alu_control), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .zero_ext(zero_ext),
    .pc_write(pc_write), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .i_or_d(i_or_d),
    .pc_source(pc_source), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .state(state),
    .illegal_instr(illegal_instr), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o = '{state, alu_control, alu_src_a, alu_src_b, zero_ext,
          pc_write, ir_write, mem_read, mem_write, reg_write,
          i_or_d, pc_source, mem_to_reg, reg_dst, illegal_instr,
          retired};
    return o;
  endfunction

  function automatic obs_t blank(input int st);
    obs_t o;
    o     = '0;
    o.st  = 4'(st);
    o.alu = ALU_CONTROL_ADD;
    o.ret = cnt;
    return o;
  endfunction

  task automatic chk(input string tag, input obs_t got, input obs_t exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h required %h", tag, got, exp);
  endtask

  function automatic logic [5:0] ref_alu(input logic [5:0] op,
                                         input logic [5:0] fn);
    logic [5:0] k;
    k = (op == 6'h00) ? fn : op;
    case (k)
      6'h22:         return ALU_CONTROL_SUB;
      6'h24, 6'h0C:  return ALU_CONTROL_AND;
      6'h25, 6'h0D:  return ALU_CONTROL_OR;
      6'h26, 6'h0E:  return ALU_CONTROL_XOR;
      default:       return ALU_CONTROL_ADD;
    endcase
  endfunction

  task automatic push(input obs_t o, input logic mrdy, input logic eqv);
    ent_t e;
    e.o = o; e.mrdy = mrdy; e.eq = eqv;
    q.push_back(e);
  endtask

  // Expected cycle-by-cycle trace of one instruction.
  task automatic build(input logic [5:0] op, input logic [5:0] fn,
                       input int fs, input int ms, input logic eqv);
    obs_t o;
    bit isr, isi, ism, isb, isj, legal;
    isr = (op == 6'h00) && (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26});
    isi = op inside {6'h08, 6'h0C, 6'h0D, 6'h0E};
    ism = op inside {6'h23, 6'h2B};
    isb = op inside {6'h04, 6'h05};
    isj = (op == 6'h02);
    legal = isr | isi | ism | isb | isj;
    for (int i = 0; i <= fs; i++) begin
      o = blank(0); o.mr = 1; o.sb = 1;
      o.pcw = (i == fs); o.irw = (i == fs);
      push(o, i == fs, 1'($urandom));
    end
    o = blank(1); o.sb = 3; o.ill = !legal;
    push(o, 1'($urandom), 1'($urandom));
    if (ism) begin
      o = blank(2); o.sa = 1; o.sb = 2;
      push(o, 1'($urandom), 1'($urandom));
      for (int i = 0; i <= ms; i++) begin
        o = blank(op == 6'h23 ? 3 : 5); o.iod = 1;
        if (op == 6'h23) o.mr = 1; else o.mw = 1;
        push(o, i == ms, 1'($urandom));
      end
      if (op == 6'h23) begin
        o = blank(4); o.rw = 1; o.m2r = 1;
        push(o, 1'($urandom), 1'($urandom));
      end
    end else if (isr) begin
      o = blank(6); o.sa = 1; o.alu = ref_alu(op, fn);
      push(o, 1'($urandom), 1'($urandom));
      o = blank(7); o.rw = 1; o.rd = 1;
      push(o, 1'($urandom), 1'($urandom));
    end else if (isb) begin
      o = blank(8); o.alu = ALU_CONTROL_SUB; o.sa = 1; o.ps = 1;
      o.pcw = (op == 6'h04) ? eqv : !eqv;
      push(o, 1'($urandom), eqv);
    end else if (isj) begin
      o = blank(9); o.ps = 2; o.pcw = 1;
      push(o, 1'($urandom), 1'($urandom));
    end else if (isi) begin
      o = blank(10); o.sa = 1; o.sb = 2; o.alu = ref_alu(op, fn);
      o.zx = (op != 6'h08);
      push(o, 1'($urandom), 1'($urandom));
      o.st = 4'd11; o.rw = 1;
      push(o, 1'($urandom), 1'($urandom));
    end
    if (legal) cnt++;
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn,
                     input int fs, input int ms, input logic eqv,
                     input string tag);
    ent_t e;
    instr_opcode = op;
    instr_funct  = fn;
    build(op, fn, fs, ms, eqv);
    while (q.size() > 0) begin
      e = q.pop_front();
      mem_ready = e.mrdy;
      operands_are_equal = e.eq;
      #1;
      chk(tag, sample(), e.o);
      @(negedge clk);
    end
  endtask

  initial begin
    obs_t o;
    logic [5:0] ops [10];
    logic [5:0] fns [5];
    logic [5:0] op, fn;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05,
            6'h02, 6'h08, 6'h0C, 6'h0D, 6'h0E};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26};

    #2;
    o = blank(0); o.mr = 1; o.sb = 1; o.pcw = 1; o.irw = 1;
    chk("reset", sample(), o);
    @(negedge clk);
    reset = 1'b0;

    run(6'h00, 6'h20, 0, 0, 1'b0, "r_add");
    run(6'h23, 6'h00, 0, 2, 1'b0, "lw_stall");
    run(6'h04, 6'h00, 0, 0, 1'b1, "beq_eq");
    run(6'h05, 6'h00, 0, 0, 1'b1, "bne_eq");
    run(6'h0D, 6'h00, 1, 0, 1'b0, "ori");
    run(6'h3F, 6'h20, 0, 0, 1'b0, "ill_op");
    run(6'h00, 6'h21, 0, 0, 1'b0, "ill_fn");
    run(6'h2B, 6'h00, 0, 1, 1'b0, "sw");
    run(6'h02, 6'h00, 2, 0, 1'b0, "j");

    for (int n = 0; n < 200; n++) begin
      op = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 9)]
                                      : 6'($urandom);
      fn = ($urandom_range(0, 4) < 4) ? fns[$urandom_range(0, 4)]
                                      : 6'($urandom);
      run(op, fn, $urandom_range(0, 2), $urandom_range(0, 2),
          1'($urandom), "rand");
    end

    // Reset lands mid-cycle while a store is stalled in MEM_WRITE.
    instr_opcode = 6'h2B;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    o = blank(5); o.mw = 1; o.iod = 1;
    chk("sw_wait", sample(), o);
    #2;
    reset = 1'b1;
    #1;
    cnt = 0;
    o = blank(0); o.mr = 1; o.sb = 1;
    chk("rst_mid", sample(), o);
    @(negedge clk);
    reset = 1'b0;
    run(6'h0E, 6'h00, 0, 0, 1'b0, "post_rst");
    run(6'h00, 6'h22, 0, 0, 1'b0, "post_sub");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running required finished");
    $fatal(1, "timeout");
  end

endmodule
